// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one 4-bit lookahead group per stage, operands skewed through stage registers.
// Optional subtract mode (sub port) is enabled by defining CLA_SUB_EN.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3;

    assign p = a ^ b;
    assign g = a & b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ {c3, c2, c1, cin};
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int GROUP = 4;
    localparam int N     = WIDTH / GROUP;
    localparam int MSB   = WIDTH - 1;

    if ((WIDTH % GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef CLA_SUB_EN
    assign b_eff   = b ^ {WIDTH{sub}};
    assign cin_eff = cin ^ sub;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Stage k registers hold the state after group k has been resolved.
    logic [WIDTH-1:0] a_pipe [N];
    logic [WIDTH-1:0] b_pipe [N];
    logic [WIDTH-1:0] s_pipe [N];
    logic [N-1:0]     c_pipe;
    logic [N-1:0]     vld_pipe;

    // What the lookahead logic of stage k sees on its inputs.
    logic [WIDTH-1:0] a_src [N];
    logic [WIDTH-1:0] b_src [N];
    logic [WIDTH-1:0] s_src [N];
    logic [WIDTH-1:0] s_nxt [N];
    logic [3:0]       g_sum [N];
    logic [N-1:0]     c_src;
    logic [N-1:0]     v_src;
    logic [N-1:0]     g_cout;

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}}) << (k * GROUP);

        if (k == 0) begin : g_first
            assign a_src[k] = a;
            assign b_src[k] = b_eff;
            assign s_src[k] = '0;
            assign c_src[k] = cin_eff;
            assign v_src[k] = in_valid;
        end else begin : g_next
            assign a_src[k] = a_pipe[k-1];
            assign b_src[k] = b_pipe[k-1];
            assign s_src[k] = s_pipe[k-1];
            assign c_src[k] = c_pipe[k-1];
            assign v_src[k] = vld_pipe[k-1];
        end

        cla4_group u_grp (
            .a    (a_src[k][k*GROUP +: GROUP]),
            .b    (b_src[k][k*GROUP +: GROUP]),
            .cin  (c_src[k]),
            .sum  (g_sum[k]),
            .cout (g_cout[k])
        );

        assign s_nxt[k] = (s_src[k] & ~GMASK) | (WIDTH'(g_sum[k]) << (k * GROUP));
    end

    assign out_valid = vld_pipe[N-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            c_pipe   <= '0;
            for (int k = 0; k < N; k++) begin
                a_pipe[k] <= '0;
                b_pipe[k] <= '0;
                s_pipe[k] <= '0;
            end
        end else if (adv) begin
            vld_pipe <= v_src;
            c_pipe   <= g_cout;
            for (int k = 0; k < N; k++) begin
                a_pipe[k] <= a_src[k];
                b_pipe[k] <= b_src[k];
                s_pipe[k] <= s_nxt[k];
            end
        end
    end

    // Overflow is derived from the final-stage registers so it leaves with sum/cout
    // and reads 0 out of reset (all registers cleared).
    assign sum  = s_pipe[N-1];
    assign cout = c_pipe[N-1];
    assign ovf  = (a_pipe[N-1][MSB] == b_pipe[N-1][MSB]) & (s_pipe[N-1][MSB] != a_pipe[N-1][MSB]);
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver pushes model results, a monitor pops on each delivered output.
module tb_cla_pipe_adder;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;
`ifdef CLA_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    cla_pipe_adder #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: exact integer arithmetic; overflow = signed result out of range.
    function automatic res_t model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic c, logic s);
        res_t             r;
        logic [WIDTH-1:0] yb;
        logic             ce;
        logic             se;
        longint           full, sx, sy, sr, lim;
        se   = s & HAS_SUB;
        yb   = se ? ~y : y;
        ce   = c ^ se;
        full = longint'(x) + longint'(yb) + longint'(ce);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        lim  = longint'(1) << (WIDTH - 1);
        sx   = x[WIDTH-1]  ? longint'(x)  - (lim << 1) : longint'(x);
        sy   = yb[WIDTH-1] ? longint'(yb) - (lim << 1) : longint'(yb);
        sr   = sx + sy + longint'(ce);
        r.ovf  = (sr >= lim) || (sr < -lim);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input logic s, input bit ordy, output bit acc);
        @(negedge clock);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(x, y, c, s));
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    // Monitor: every delivered result must match the oldest outstanding expectation.
    always @(negedge clock) begin
        res_t e;
        #1;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0h with no outstanding transaction", sum);
            end else begin
                e = exp_q.pop_front();
                check("sum",  64'(sum),  64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf",  64'(ovf),  64'(e.ovf));
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        bit               acc;
        int               lat;
        bit               got;
        int               issued;
        logic [WIDTH-1:0] snap_sum;
        logic             snap_cout;
        logic [WIDTH-1:0] xa [8];
        logic [WIDTH-1:0] xb [8];

        // Reset state, sampled while reset is held
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Latency of a single transaction
        drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, acc);
        check("first_accept", 64'(acc), 64'd1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            lat++;
            if (out_valid) got = 1'b1;
        end
        check("latency", 64'(lat), 64'(N));
        idle(2);

        // Carry wrap, signed overflow, and subtract when built in
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, acc);
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc);
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, acc);
        drive(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, acc);
        if (HAS_SUB) begin
            drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, acc);
            drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, acc);
        end
        idle(N + 3);
        check("directed_drained", 64'(exp_q.size()), 64'd0);

        // 8 back-to-back with out_ready low for cycles 6..9
        for (int i = 0; i < 8; i++) begin
            xa[i] = WIDTH'($urandom);
            xb[i] = WIDTH'($urandom);
        end
        issued = 0;
        for (int t = 0; t < 30; t++) begin
            if (issued < 8)
                drive(1'b1, xa[issued], xb[issued], 1'(t & 1), 1'b0, !(t >= 6 && t <= 9), acc);
            else
                drive(1'b0, '0, '0, 1'b0, 1'b0, !(t >= 6 && t <= 9), acc);
            if (acc) issued++;
            if (t >= 6 && t <= 9) begin
                check("stall_in_ready",  64'(in_ready),  64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                if (t == 6) begin
                    snap_sum  = sum;
                    snap_cout = cout;
                end else begin
                    check("stall_sum_hold",  64'(sum),  64'(snap_sum));
                    check("stall_cout_hold", 64'(cout), 64'(snap_cout));
                end
            end
        end
        check("stall_issued",  64'(issued),        64'd8);
        check("stall_drained", 64'(exp_q.size()),  64'd0);

        // Reset with transactions in flight
        for (int i = 0; i < 5; i++)
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1, acc);
        @(posedge clock);
        #2;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum",       64'(sum),       64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, acc);
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, acc);
        idle(N + 3);
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic with random valid and backpressure
        for (int i = 0; i < 4000; i++)
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, acc);
        idle(N + 6);
        check("random_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
